// File: rtl/fifo_mc.sv
// Multi-channel synchronous FIFO: NUM_CH independent queues sharing one push port
// and one pop port, with per-channel flush, usage, almost-full and sticky error flags.
module fifo_mc #(
  parameter logic        FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned AF_THRESH    = DEPTH - 1,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_W       = $clog2(DEPTH),
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              flush_i,
  input  logic                           clr_err_i,
  input  logic                           push_i,
  input  logic [CH_W-1:0]                push_ch_i,
  input  dtype                           data_i,
  input  logic                           pop_i,
  input  logic [CH_W-1:0]                pop_ch_i,
  output dtype                           data_o,
  output logic [NUM_CH-1:0]              full_o,
  output logic [NUM_CH-1:0]              almost_full_o,
  output logic [NUM_CH-1:0]              empty_o,
  output logic [NUM_CH*(ADDR_W+1)-1:0]   usage_o,
  output logic [NUM_CH-1:0]              overflow_o,
  output logic [NUM_CH-1:0]              underflow_o
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned SLOTS  = NUM_CH * DEPTH;
  localparam int unsigned MEM_AW = $clog2(SLOTS);

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_mc: DEPTH must be at least 2");
  end
  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("fifo_mc: NUM_CH must be at least 1");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
    $error("fifo_mc: AF_THRESH must lie in 1..DEPTH");
  end

  ptr_t              rptr_q [NUM_CH];
  ptr_t              rptr_d [NUM_CH];
  ptr_t              wptr_q [NUM_CH];
  ptr_t              wptr_d [NUM_CH];
  cnt_t              cnt_q  [NUM_CH];
  cnt_t              cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] udf_q, udf_d;

  dtype              mem_q [SLOTS];
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;

  logic [NUM_CH-1:0] push_hit, pop_hit, byp_pop;
  logic [NUM_CH-1:0] push_acc, pop_acc, ovf_evt, udf_evt;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic logic [MEM_AW-1:0] slot(input int unsigned ch, input ptr_t p);
    return MEM_AW'(ch * DEPTH + 32'(p));
  endfunction

  // Per-channel request decode and acceptance; flush swallows any same-cycle request.
  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    byp_pop  = '0;
    push_acc = '0;
    pop_acc  = '0;
    ovf_evt  = '0;
    udf_evt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_hit[c] = push_i && (push_ch_i == CH_W'(c));
      pop_hit[c]  = pop_i && (pop_ch_i == CH_W'(c));
      byp_pop[c]  = FALL_THROUGH && (cnt_q[c] == '0) && push_hit[c] && pop_hit[c];
      push_acc[c] = push_hit[c] && (cnt_q[c] != CNT_W'(DEPTH)) && !flush_i[c] && !byp_pop[c];
      pop_acc[c]  = pop_hit[c] && (cnt_q[c] != '0) && !flush_i[c];
      ovf_evt[c]  = push_hit[c] && (cnt_q[c] == CNT_W'(DEPTH)) && !flush_i[c];
      udf_evt[c]  = pop_hit[c] && (cnt_q[c] == '0) && !flush_i[c] && !byp_pop[c];
    end
  end

  // Next-state for pointers, counts, error flags and the memory write port.
  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    ovf_d     = (clr_err_i ? '0 : ovf_q) | ovf_evt;
    udf_d     = (clr_err_i ? '0 : udf_q) | udf_evt;
    for (int c = 0; c < NUM_CH; c++) begin
      if (flush_i[c]) begin
        rptr_d[c] = '0;
        wptr_d[c] = '0;
        cnt_d[c]  = '0;
      end else begin
        if (push_acc[c]) begin
          wptr_d[c] = ptr_inc(wptr_q[c]);
          mem_we    = 1'b1;
          mem_waddr = slot(c, wptr_q[c]);
        end
        if (pop_acc[c]) begin
          rptr_d[c] = ptr_inc(rptr_q[c]);
        end
        case ({push_acc[c], pop_acc[c]})
          2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
          2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
          default: cnt_d[c] = cnt_q[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q <= '{default: '0};
      wptr_q <= '{default: '0};
      cnt_q  <= '{default: '0};
      ovf_q  <= '0;
      udf_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= data_i;
    end
  end

  always_comb begin
    full_o        = '0;
    almost_full_o = '0;
    empty_o       = '0;
    usage_o       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full_o[c]                 = (cnt_q[c] == CNT_W'(DEPTH));
      almost_full_o[c]          = (cnt_q[c] >= CNT_W'(AF_THRESH));
      empty_o[c]                = (cnt_q[c] == '0) && !(FALL_THROUGH && push_hit[c]);
      usage_o[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

  // Head of the selected channel, or the incoming word when it falls through.
  always_comb begin
    data_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pop_ch_i == CH_W'(c)) begin
        if (FALL_THROUGH && (cnt_q[c] == '0) && push_hit[c]) begin
          data_o = data_i;
        end else if (cnt_q[c] != '0) begin
          data_o = mem_q[slot(c, rptr_q[c])];
        end
      end
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: tb/tb_fifo_mc.sv
// Bench for fifo_mc: two instances (plain and fall-through) on shared inputs, a directed
// table, hand sequences and random traffic, all checked against a queue-based model.
module tb_fifo_mc;

  localparam int unsigned NCH = 4;
  localparam int unsigned DEP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flush;
  logic       clr;
  logic       push;
  logic [1:0] push_ch;
  logic [7:0] din;
  logic       pop;
  logic [1:0] pop_ch;

  logic [7:0]  data_w  [2];
  logic [3:0]  full_w  [2];
  logic [3:0]  af_w    [2];
  logic [3:0]  empty_w [2];
  logic [11:0] usage_w [2];
  logic [3:0]  ovf_w   [2];
  logic [3:0]  udf_w   [2];

  int nvec = 0;
  int nmis = 0;
  bit model_valid = 1'b0;

  logic [7:0] mq [8][$];
  logic [3:0] movf [2];
  logic [3:0] mudf [2];

  typedef struct packed {
    logic        rn;
    logic [3:0]  fl;
    logic        cl;
    logic        pu;
    logic [1:0]  pch;
    logic [7:0]  d;
    logic        po;
    logic [1:0]  och;
    logic [7:0]  e_data;
    logic [11:0] e_usage;
    logic [3:0]  e_empty;
    logic [3:0]  e_full;
    logic [3:0]  e_af;
    logic [3:0]  e_ovf;
    logic [3:0]  e_udf;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  fifo_mc #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(DEP), .NUM_CH(NCH), .AF_THRESH(3)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
    .push_i(push), .push_ch_i(push_ch), .data_i(din), .pop_i(pop), .pop_ch_i(pop_ch),
    .data_o(data_w[0]), .full_o(full_w[0]), .almost_full_o(af_w[0]), .empty_o(empty_w[0]),
    .usage_o(usage_w[0]), .overflow_o(ovf_w[0]), .underflow_o(udf_w[0])
  );

  fifo_mc #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(DEP), .NUM_CH(NCH), .AF_THRESH(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
    .push_i(push), .push_ch_i(push_ch), .data_i(din), .pop_i(pop), .pop_ch_i(pop_ch),
    .data_o(data_w[1]), .full_o(full_w[1]), .almost_full_o(af_w[1]), .empty_o(empty_w[1]),
    .usage_o(usage_w[1]), .overflow_o(ovf_w[1]), .underflow_o(udf_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mq[i].delete();
    for (int d = 0; d < 2; d++) begin
      movf[d] = '0;
      mudf[d] = '0;
    end
  endtask

  // Expected outputs derived from queue occupancy and the current inputs.
  task automatic model_check();
    logic [7:0]  e_data;
    logic [11:0] e_usage;
    logic [3:0]  e_full, e_af, e_empty;
    int          n;
    if (!model_valid) return;
    for (int d = 0; d < 2; d++) begin
      e_usage = '0;
      e_full  = '0;
      e_af    = '0;
      e_empty = '0;
      for (int c = 0; c < 4; c++) begin
        n = mq[d*4+c].size();
        e_usage[c*3 +: 3] = 3'(n);
        e_full[c]  = (n == DEP);
        e_af[c]    = (n >= 3);
        e_empty[c] = (n == 0) && !((d == 1) && push && (push_ch == 2'(c)));
      end
      n = mq[d*4 + int'(pop_ch)].size();
      if ((d == 1) && (n == 0) && push && (push_ch == pop_ch)) e_data = din;
      else if (n > 0) e_data = mq[d*4 + int'(pop_ch)][0];
      else e_data = 8'h00;
      chk($sformatf("dut%0d data_o", d), 32'(data_w[d]), 32'(e_data));
      chk($sformatf("dut%0d usage_o", d), 32'(usage_w[d]), 32'(e_usage));
      chk($sformatf("dut%0d full_o", d), 32'(full_w[d]), 32'(e_full));
      chk($sformatf("dut%0d almost_full_o", d), 32'(af_w[d]), 32'(e_af));
      chk($sformatf("dut%0d empty_o", d), 32'(empty_w[d]), 32'(e_empty));
      chk($sformatf("dut%0d overflow_o", d), 32'(ovf_w[d]), 32'(movf[d]));
      chk($sformatf("dut%0d underflow_o", d), 32'(udf_w[d]), 32'(mudf[d]));
    end
  endtask

  // Clock-edge update of the reference queues.
  task automatic model_step();
    logic [3:0] nov, nud;
    int         n;
    bit         pc, oc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      nov = clr ? 4'b0 : movf[d];
      nud = clr ? 4'b0 : mudf[d];
      for (int c = 0; c < 4; c++) begin
        n  = mq[d*4+c].size();
        pc = push && (push_ch == 2'(c));
        oc = pop && (pop_ch == 2'(c));
        if (flush[c]) begin
          mq[d*4+c].delete();
        end else if (!((d == 1) && (n == 0) && pc && oc)) begin
          if (oc) begin
            if (n > 0) void'(mq[d*4+c].pop_front());
            else nud[c] = 1'b1;
          end
          if (pc) begin
            if (n == DEP) nov[c] = 1'b1;
            else mq[d*4+c].push_back(din);
          end
        end
      end
      movf[d] = nov;
      mudf[d] = nud;
    end
  endtask

  task automatic drive(input logic rn, input logic [3:0] fl, input logic cl, input logic pu,
                       input logic [1:0] pch, input logic [7:0] d, input logic po,
                       input logic [1:0] och);
    rst_n = rn; flush = fl; clr = cl; push = pu; push_ch = pch; din = d; pop = po; pop_ch = och;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add(input logic rn, input logic [3:0] fl, input logic cl, input logic pu,
                     input logic [1:0] pch, input logic [7:0] d, input logic po,
                     input logic [1:0] och, input logic [7:0] ed, input logic [11:0] eu,
                     input logic [3:0] ee, input logic [3:0] ef, input logic [3:0] ea,
                     input logic [3:0] eo, input logic [3:0] eud);
    vt.push_back('{rn, fl, cl, pu, pch, d, po, och, ed, eu, ee, ef, ea, eo, eud});
  endtask

  initial begin
    vec_t v;
    // Expectations for the non-fall-through instance, sampled before each edge.
    //   rn fl    cl pu ch d      po och  data   usage    empty  full  af    ovf   udf
    add(1, 4'h0, 0, 1, 2, 8'hA0, 0, 2,  8'h00, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 2, 8'hA1, 0, 2,  8'hA0, 12'h040, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 2, 8'hA2, 0, 2,  8'hA0, 12'h080, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 2, 8'hA3, 0, 2,  8'hA0, 12'h0C0, 4'hB, 4'h0, 4'h4, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 2,  8'hA0, 12'h100, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 2,  8'hA1, 12'h0C0, 4'hB, 4'h0, 4'h4, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 2,  8'hA2, 12'h080, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 2,  8'hA3, 12'h040, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 0, 2,  8'h00, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'h10, 0, 0,  8'h00, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 3, 8'h30, 0, 0,  8'h10, 12'h001, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'h11, 1, 3,  8'h30, 12'h201, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 0, 0,  8'h10, 12'h002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 0,  8'h10, 12'h002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 0,  8'h11, 12'h001, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'hB0, 0, 0,  8'h00, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'hB1, 0, 0,  8'hB0, 12'h001, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'hB2, 0, 0,  8'hB0, 12'h002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'hB3, 0, 0,  8'hB0, 12'h003, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'hEE, 0, 0,  8'hB0, 12'h004, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 1,  8'h00, 12'h004, 4'hE, 4'h1, 4'h1, 4'h1, 4'h0);
    add(1, 4'h0, 1, 0, 0, 8'h00, 0, 0,  8'hB0, 12'h004, 4'hE, 4'h1, 4'h1, 4'h1, 4'h2);
    add(1, 4'h0, 1, 1, 0, 8'hEF, 0, 0,  8'hB0, 12'h004, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 0, 8'hF0, 1, 0,  8'hB0, 12'h004, 4'hE, 4'h1, 4'h1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 0, 0,  8'hB1, 12'h003, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0);
    add(1, 4'h0, 1, 0, 0, 8'h00, 0, 0,  8'hB1, 12'h003, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0);
    add(1, 4'h0, 0, 1, 2, 8'hC0, 0, 2,  8'h00, 12'h003, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 2, 8'hC1, 0, 2,  8'hC0, 12'h043, 4'hA, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 2, 8'hC2, 0, 2,  8'hC0, 12'h083, 4'hA, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 3, 8'hD0, 0, 2,  8'hC0, 12'h0C3, 4'hA, 4'h0, 4'h5, 4'h0, 4'h0);
    add(1, 4'h4, 0, 1, 2, 8'hC3, 0, 2,  8'hC0, 12'h2C3, 4'h2, 4'h0, 4'h5, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 0, 3,  8'hD0, 12'h203, 4'h6, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 0, 0, 8'h00, 1, 1,  8'h00, 12'h203, 4'h6, 4'h0, 4'h1, 4'h0, 4'h0);
    add(0, 4'h0, 0, 1, 1, 8'h77, 0, 0,  8'hB1, 12'h203, 4'h6, 4'h0, 4'h1, 4'h0, 4'h2);
    add(1, 4'h0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

    rst_n = 1'b0; flush = '0; clr = 1'b0; push = 1'b0; push_ch = '0; din = '0;
    pop = 1'b0; pop_ch = '0;
    repeat (2) @(posedge clk);
    model_reset();
    model_valid = 1'b1;
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      drive(v.rn, v.fl, v.cl, v.pu, v.pch, v.d, v.po, v.och);
      chk($sformatf("row%0d data_o", i), 32'(data_w[0]), 32'(v.e_data));
      chk($sformatf("row%0d usage_o", i), 32'(usage_w[0]), 32'(v.e_usage));
      chk($sformatf("row%0d empty_o", i), 32'(empty_w[0]), 32'(v.e_empty));
      chk($sformatf("row%0d full_o", i), 32'(full_w[0]), 32'(v.e_full));
      chk($sformatf("row%0d almost_full_o", i), 32'(af_w[0]), 32'(v.e_af));
      chk($sformatf("row%0d overflow_o", i), 32'(ovf_w[0]), 32'(v.e_ovf));
      chk($sformatf("row%0d underflow_o", i), 32'(udf_w[0]), 32'(v.e_udf));
      tick();
    end

    // Steady push+pop on ch1 with two entries resident; pointers wrap repeatedly.
    drive(1, 4'h0, 0, 1, 1, 8'hE0, 0, 1); tick();
    drive(1, 4'h0, 0, 1, 1, 8'hE1, 0, 1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'h0, 0, 1, 1, 8'(8'hE2 + i), 1, 1);
      chk("wrap data_o", 32'(data_w[0]), 32'(8'hE0 + i));
      chk("wrap usage1", 32'(usage_w[0][5:3]), 32'd2);
      chk("wrap usage1 ft", 32'(usage_w[1][5:3]), 32'd2);
      tick();
    end

    // Fall-through word passes straight from data_i to data_o.
    drive(1, 4'h0, 0, 1, 0, 8'h55, 1, 0);
    chk("ft bypass data_o", 32'(data_w[1]), 32'h55);
    tick();
    drive(1, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    chk("ft bypass usage0", 32'(usage_w[1][2:0]), 32'd0);
    chk("ft bypass underflow0", 32'(udf_w[1][0]), 32'd0);
    tick();
    drive(1, 4'h0, 0, 1, 0, 8'h66, 0, 0);
    chk("ft push empty0", 32'(empty_w[1][0]), 32'd0);
    chk("ft push data_o", 32'(data_w[1]), 32'h66);
    tick();
    drive(1, 4'h0, 0, 0, 0, 8'h00, 0, 0);
    chk("ft push usage0", 32'(usage_w[1][2:0]), 32'd1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0,
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 6),
            2'($urandom),
            8'($urandom),
            ($urandom_range(0, 9) < 5),
            2'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
